// File: rtl/cpu_types.sv
// Shared core types for the OTTER out-of-order core.
//   RS_tag_type : reservation-station tag carried with every result
//   INVALID     : tag value meaning "no station"; the CDB idles with it
//   NUM_CDB_SRC : number of functional units that drive the CDB
package cpu_types;

   typedef logic [3:0] RS_tag_type;

   localparam RS_tag_type INVALID = 4'hF;

   localparam int NUM_CDB_SRC = 4;

endpackage

// File: rtl/cdb_arbiter_rr_priority_select.sv
// Rotating-priority one-hot select, purely combinational.
// Ports:
//   req   in  N      request vector
//   ptr   in  PTR_W  index holding highest priority this cycle
//   grant out N      one-hot of first request at or above ptr (wrapping)
//   idx   out PTR_W  encoded index of the grant
//   any   out 1      at least one request present
module rr_priority_select #(
   parameter int N     = 4,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [PTR_W-1:0] idx,
   output logic             any
);

   int j;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         // Explicit modulo so non-power-of-two N wraps at N-1, not at 2^PTR_W.
         j = (int'(ptr) + k) % N;
         if (!any && req[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            idx      = PTR_W'(j);
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter driving the registered Common Data Bus.
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   fu_req        per-FU result-ready request
//   fu_tag/fu_val per-FU reservation-station tag and 32-bit result
//   fu_grant      combinational one-hot grant (doubles as RS "done")
//   CDB_valid/CDB_tag/CDB_val  registered broadcast of the winner
//   conflict_cnt  saturating count of cycles with two or more requests
module cdb_arbiter
   import cpu_types::*;
#(
   parameter int NUM_FU = NUM_CDB_SRC,
   parameter int CNT_W  = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [NUM_FU-1:0] fu_req,
   input  RS_tag_type        fu_tag [NUM_FU],
   input  logic [31:0]       fu_val [NUM_FU],
   output logic [NUM_FU-1:0] fu_grant,
   output logic              CDB_valid,
   output RS_tag_type        CDB_tag,
   output logic [31:0]       CDB_val,
   output logic [CNT_W-1:0]  conflict_cnt
);

   localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

   logic [PTR_W-1:0]  ptr;
   logic [PTR_W-1:0]  sel_idx;
   logic              sel_any;
   logic [NUM_FU-1:0] req_eff;
   logic              multi_req;

   // Masking requests during reset keeps any transfer from completing.
   assign req_eff   = RST ? '0 : fu_req;
   assign multi_req = ($countones(fu_req) >= 2);

   rr_priority_select #(
      .N     (NUM_FU),
      .PTR_W (PTR_W)
   ) u_sel (
      .req   (req_eff),
      .ptr   (ptr),
      .grant (fu_grant),
      .idx   (sel_idx),
      .any   (sel_any)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         ptr          <= '0;
         CDB_valid    <= 1'b0;
         CDB_tag      <= INVALID;
         CDB_val      <= '0;
         conflict_cnt <= '0;
      end else begin
         if (sel_any) begin
            ptr       <= (sel_idx == PTR_W'(NUM_FU - 1)) ? '0 : sel_idx + PTR_W'(1);
            CDB_valid <= 1'b1;
            CDB_tag   <= fu_tag[sel_idx];
            CDB_val   <= fu_val[sel_idx];
         end else begin
            CDB_valid <= 1'b0;
            CDB_tag   <= INVALID;
            CDB_val   <= '0;
         end
         if (multi_req && (conflict_cnt != '1))
            conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
   import cpu_types::*;

   localparam int N = 4;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic [N-1:0]  fu_req = '0;
   RS_tag_type    fu_tag [N];
   logic [31:0]   fu_val [N];
   logic [N-1:0]  fu_grant, fu_grant_s;
   logic          CDB_valid, CDB_valid_s;
   RS_tag_type    CDB_tag, CDB_tag_s;
   logic [31:0]   CDB_val, CDB_val_s;
   logic [15:0]   conflict_cnt;
   logic [3:0]    conflict_cnt_s;

   always #5 CLK = ~CLK;

   cdb_arbiter #(.NUM_FU(N), .CNT_W(16)) dut (
      .CLK(CLK), .RST(RST), .fu_req(fu_req), .fu_tag(fu_tag), .fu_val(fu_val),
      .fu_grant(fu_grant), .CDB_valid(CDB_valid), .CDB_tag(CDB_tag),
      .CDB_val(CDB_val), .conflict_cnt(conflict_cnt)
   );

   cdb_arbiter #(.NUM_FU(N), .CNT_W(4)) dut_sat (
      .CLK(CLK), .RST(RST), .fu_req(fu_req), .fu_tag(fu_tag), .fu_val(fu_val),
      .fu_grant(fu_grant_s), .CDB_valid(CDB_valid_s), .CDB_tag(CDB_tag_s),
      .CDB_val(CDB_val_s), .conflict_cnt(conflict_cnt_s)
   );

   int checks = 0;
   int errors = 0;

   // reference model state
   int          m_ptr = 0;
   int          m_cnt = 0;
   int          m_cnt_s = 0;
   logic        m_valid = 1'b0;
   RS_tag_type  m_tag = INVALID;
   logic [31:0] m_val = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int model_grant(input logic [N-1:0] req);
      for (int k = 0; k < N; k++)
         if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction

   // One clock cycle: apply inputs, check grant, clock, check registered outputs.
   task automatic step(input logic rst_v, input logic [N-1:0] req_v, output int g);
      logic [N-1:0] exp_g;
      RST    = rst_v;
      fu_req = req_v;
      #1;
      g     = rst_v ? -1 : model_grant(req_v);
      exp_g = '0;
      if (g >= 0) exp_g[g] = 1'b1;
      check("grant", 64'(fu_grant), 64'(exp_g));
      check("grant_sat", 64'(fu_grant_s), 64'(exp_g));
      @(posedge CLK);
      if (rst_v) begin
         m_ptr = 0; m_cnt = 0; m_cnt_s = 0;
         m_valid = 1'b0; m_tag = INVALID; m_val = '0;
      end else begin
         if ($countones(req_v) >= 2) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt_s < 15) m_cnt_s++;
         end
         if (g >= 0) begin
            m_valid = 1'b1; m_tag = fu_tag[g]; m_val = fu_val[g];
            m_ptr = (g + 1) % N;
         end else begin
            m_valid = 1'b0; m_tag = INVALID; m_val = '0;
         end
      end
      #1;
      check("cdb_valid", 64'(CDB_valid), 64'(m_valid));
      check("cdb_tag", 64'(CDB_tag), 64'(m_tag));
      check("cdb_val", 64'(CDB_val), 64'(m_val));
      check("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
      check("conflict_cnt_sat", 64'(conflict_cnt_s), 64'(m_cnt_s));
   endtask

   initial begin
      int g;
      logic [N-1:0] rq;
      for (int i = 0; i < N; i++) begin
         fu_tag[i] = RS_tag_type'($urandom_range(0, 14));
         fu_val[i] = $urandom;
      end
      @(posedge CLK); #1;

      // reset with all requesting
      step(1'b1, 4'b1111, g);
      step(1'b1, 4'b1111, g);
      check("rst_grant", 64'(fu_grant), 64'(0));
      check("rst_tag", 64'(CDB_tag), 64'(INVALID));
      check("rst_cnt", 64'(conflict_cnt), 64'(0));

      // single requester
      fu_tag[2] = 4'd5; fu_val[2] = 32'hDEAD_BEEF;
      step(1'b0, 4'b0100, g);
      check("single_idx", 64'(g), 64'(2));
      check("single_valid", 64'(CDB_valid), 64'(1));
      check("single_tag", 64'(CDB_tag), 64'(5));
      check("single_val", 64'(CDB_val), 64'(32'hDEAD_BEEF));

      // wrap from ptr=3 and skip
      step(1'b0, 4'b0011, g);
      check("wrap_first", 64'(g), 64'(0));
      step(1'b0, 4'b0010, g);
      check("wrap_second", 64'(g), 64'(1));
      step(1'b0, 4'b0000, g);
      check("idle_tag", 64'(CDB_tag), 64'(INVALID));
      step(1'b0, 4'b0000, g);
      step(1'b0, 4'b0110, g);
      check("ptr_held", 64'(g), 64'(2));

      // reset mid-stream
      step(1'b1, 4'b0000, g);
      step(1'b0, 4'b1010, g);
      check("mid_pre", 64'(g), 64'(1));
      step(1'b1, 4'b1000, g);
      check("mid_rst_valid", 64'(CDB_valid), 64'(0));
      check("mid_rst_tag", 64'(CDB_tag), 64'(INVALID));
      step(1'b0, 4'b1010, g);
      check("mid_post", 64'(g), 64'(1));

      // saturation round-robin from ptr=0
      step(1'b1, 4'b0000, g);
      for (int c = 0; c < 8; c++) begin
         fu_tag[c % N] = RS_tag_type'($urandom);
         step(1'b0, 4'b1111, g);
         check("rr_order", 64'(g), 64'(c % N));
      end
      check("rr_cnt", 64'(conflict_cnt), 64'(8));

      // two requesters for 20 cycles: 4-bit counter saturates
      step(1'b1, 4'b0000, g);
      for (int c = 0; c < 20; c++) begin
         step(1'b0, 4'b0011, g);
         if (g >= 0) begin
            fu_tag[g] = RS_tag_type'($urandom);
            fu_val[g] = $urandom;
         end
      end
      check("sat_cnt", 64'(conflict_cnt_s), 64'(15));
      check("sat_wide_cnt", 64'(conflict_cnt), 64'(20));

      // randomized traffic honouring the hold-until-granted rule
      rq = '0;
      for (int c = 0; c < 2000; c++) begin
         logic rst_v;
         rst_v = ($urandom_range(0, 199) == 0);
         step(rst_v, rq, g);
         if (g >= 0) begin
            if ($urandom_range(0, 1) == 0) rq[g] = 1'b0;
            else begin
               fu_tag[g] = RS_tag_type'($urandom);
               fu_val[g] = $urandom;
            end
         end
         for (int i = 0; i < N; i++) begin
            if (!rq[i] && ($urandom_range(0, 9) < 4)) begin
               rq[i]     = 1'b1;
               fu_tag[i] = RS_tag_type'($urandom);
               fu_val[i] = $urandom;
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter for the Common Data Bus of the out-of-order OTTER core. Each functional unit (ALU, load, store, branch) raises a completion request carrying its reservation-station tag and 32-bit result. The arbiter grants exactly one requester per cycle and broadcasts the winner's tag/value on a registered CDB. All reservation stations and the map table snoop that CDB. The grant also serves as the `done` signal that frees the issuing reservation station.

## Interface
Parameters:
- `NUM_FU`, default 4: number of requesting functional units, 2..8.
- `CNT_W`, default 16: width of the saturating conflict counter.

Ports:
- `CLK`  in  1  core clock; the only clock.
- `RST`  in  1  synchronous, active-high reset.
- `fu_req`  in  NUM_FU  per-FU result-ready request.
- `fu_tag`  in  NUM_FU x RS_tag_type  tag of the reservation station that issued the result.
- `fu_val`  in  NUM_FU x 32  result value.
- `fu_grant`  out  NUM_FU  one-hot grant; combinational, same cycle as `fu_req`.
- `CDB_valid`  out  1  registered broadcast valid.
- `CDB_tag`  out  RS_tag_type  registered broadcast tag; `INVALID` when `CDB_valid`=0.
- `CDB_val`  out  32  registered broadcast value; 0 when `CDB_valid`=0.
- `conflict_cnt`  out  CNT_W  count of cycles in which ≥2 FUs requested, saturating.

## Operation
- A transfer occurs on a cycle where `fu_req[i] && fu_grant[i]`.
- After a transfer the FU drops or replaces its request on the next cycle.
- An FU that is not granted holds `fu_req`, `fu_tag` and `fu_val` stable until it is granted.
- Grant rules:
  - `fu_grant` is zero when `fu_req` is zero.
  - Otherwise `fu_grant` is the one-hot of the first requesting index found scanning upward from priority pointer `ptr`, wrapping from NUM_FU-1 to 0.
  - `fu_grant[i]` is never asserted while `fu_req[i]`=0.
- Pointer:
  - `ptr` is $clog2(NUM_FU) bits; reset value 0.
  - On any transfer, `ptr` becomes (granted index + 1) mod NUM_FU. The wrap is explicit; it is not power-of-two truncation.
  - With no request, `ptr` holds.
- CDB register:
  - On a transfer: `CDB_valid`←1, `CDB_tag`←`fu_tag[g]`, `CDB_val`←`fu_val[g]`.
  - Otherwise: `CDB_valid`←0, `CDB_tag`←`INVALID`, `CDB_val`←0.
- Conflict counter: increments by 1 on each cycle where the popcount of `fu_req` is ≥2. It holds at all-ones.
- A request whose `fu_tag` equals `INVALID` is still arbitrated and broadcast. Tag legality is the dispatcher's responsibility.
- Fairness: a continuously requesting FU is granted within NUM_FU cycles.

## Timing
- Reset, evaluated on a `CLK` rising edge with `RST`=1:
  - `ptr`=0, `CDB_valid`=0, `CDB_tag`=`INVALID`, `CDB_val`=0, `conflict_cnt`=0.
- During `RST`, `fu_grant` is forced to 0, so no transfer can complete.
- Reset applied mid-stream:
  - In-flight requests are not granted that cycle.
  - The CDB entry registered on the previous edge is cleared at the reset edge.
- Latency: a request is granted in cycle N and appears on the CDB in cycle N+1. Back-to-back broadcasts every cycle are supported.
- Single requester: granted the same cycle regardless of `ptr`.
- Throughput: one broadcast per cycle maximum.

## Structure
- The following come from package `cpu_types`; no new package is created:
  - `RS_tag_type`
  - `INVALID`
- Add `NUM_CDB_SRC` = 4 to `cpu_types` as the core-level default for `NUM_FU`.
- One sub-module, `rr_priority_select`:
  - Parameterised by N.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant, encoded index, and `any`.
  - Purely combinational.
  - The pointer register, CDB registers and counter stay in `cdb_arbiter`.

## Test plan
- Reset check: hold `RST`=1 for 2 cycles with `fu_req`=4'b1111.
  - `fu_grant`=0, `CDB_valid`=0, `CDB_tag`=`INVALID`, `conflict_cnt`=0.
- Single requester: release reset; assert only `fu_req[2]` with tag 5 and value 32'hDEAD_BEEF.
  - Same cycle: `fu_grant`=4'b0100.
  - Next cycle: `CDB_valid`=1, `CDB_tag`=5, `CDB_val`=32'hDEAD_BEEF.
  - Afterwards `ptr`=3.
- Round-robin under saturation: hold `fu_req`=4'b1111 for 8 cycles, starting from `ptr`=0.
  - Grants 0,1,2,3,0,1,2,3.
  - CDB valid on every cycle from the second onward.
  - `conflict_cnt`=8.
- Wrap and skip: set `ptr`=3 (via a prior grant to FU2) with `fu_req`=4'b0011.
  - Grant FU0, then FU1.
  - Idle cycles leave `ptr` held and drive `CDB_tag`=`INVALID`.
- Reset mid-stream: with `fu_req`=4'b1010, assert `RST` the cycle after granting FU1.
  - CDB cleared at the reset edge.
  - After release, `ptr`=0 and the first grant is FU1.
- Counter saturation (`CNT_W`=4): hold 2 requesters for 20 cycles.
  - `conflict_cnt` reaches 15 and stays there.
